// File: rtl/nes_oam_dma.sv
// nes_oam_dma: sprite DMA controller; halts the CPU and copies page {page,00..FF} to the OAM data port.
// Optional macro OAM_DMA_ALIGN_EN inserts the parity-driven ALIGN cycle for hardware-accurate 513/514-cycle timing.
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_a,
  output logic [7:0]  dma_dout,
  output logic        dma_rw,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t     state_q, state_d, halt_exit;
  logic [7:0] page_q, page_d, idx_q, idx_d, data_q, data_d;
  logic       done_q, done_d;
`ifdef OAM_DMA_ALIGN_EN
  logic p_q;
  // Cycle parity: p==0 marks get cycles, the only cycles a READ may occupy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p_q <= 1'b0;
    else        p_q <= ~p_q;
  // Halt cycle with p==0 means the next cycle is a put cycle, so burn one ALIGN cycle
  assign halt_exit = p_q ? READ : ALIGN;
`else
  assign halt_exit = READ;
`endif
  // State, page, index, read data and done pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  // Next-state: trigger on page-register write, wait out CPU writes, then alternate READ/WRITE 256 times
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (!cpu_rw && cpu_a == DMA_REG_ADDR) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      HALT:  state_d = cpu_rw ? halt_exit : HALT;
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        done_d  = idx_q == 8'hFF;
        state_d = idx_q == 8'hFF ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  // Moore output decode of registered state
  always_comb begin
    rdy        = state_q == IDLE;
    dma_active = state_q == READ || state_q == WRITE;
    dma_rw     = state_q != WRITE;
    dma_a      = state_q == READ ? {page_q, idx_q} : state_q == WRITE ? OAM_DATA_ADDR : 16'h0000;
    dma_dout   = state_q == WRITE ? data_q : 8'h00;
    done       = done_q;
  end
endmodule
